vga_timing_controller: RTL
==========================

// Module: vga_timing_controller
// PURPOSE
//   Sequences the VGA raster. Owns the horizontal (0..H_TOTAL-1) and vertical
//   (0..V_TOTAL-1) counters and advances them on a divided pixel tick.
//   Decodes hsync, vsync, the visible-area flag and pixel coordinates from them.
//   Sits between the system clock and the pixel generator / video DAC pins.
// PARAMETERS
//   CLK_DIV   2    system clocks per pixel tick (>=1; 1 = tick every clock)
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch, pixels
//   H_SYNC    96   horizontal sync width, pixels
//   H_BP      48   horizontal back porch, pixels (H_TOTAL = 800)
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch, lines
//   V_SYNC    2    vertical sync width, lines
//   V_BP      33   vertical back porch, lines (V_TOTAL = 525)
//   SYNC_POL  0    sync level when asserted (0 = active-low sync)
// PORTS
//   Clk         in   1   system clock, all logic on rising edge
//   reset       in   1   asynchronous, active-low; 0 clears all state at once
//   enable      in   1   1 = raster runs; 0 = raster held at origin
//   pixel_tick  out  1   1-Clk pulse; counters advance on the Clk edge where it is 1
//   pixel_x     out  10  current horizontal count
//   pixel_y     out  10  current vertical count
//   hsync       out  1   horizontal sync, level per SYNC_POL
//   vsync       out  1   vertical sync, level per SYNC_POL
//   video_on    out  1   1 while pixel_x<H_ACTIVE and pixel_y<V_ACTIVE
//   line_end    out  1   1 while pixel_x==H_TOTAL-1 and pixel_tick==1
//   frame_end   out  1   line_end and pixel_y==V_TOTAL-1
// BEHAVIOUR
//   - Reset (reset=0): tick divider=0, pixel_x=0, pixel_y=0, pixel_tick=0,
//     video_on=0, line_end=0, frame_end=0, hsync=vsync=~SYNC_POL.
//   - Divider: counts 0..CLK_DIV-1 while enable=1.
//     pixel_tick=1 for one Clk when the divider is at CLK_DIV-1.
//   - On each tick: if pixel_x==H_TOTAL-1, pixel_x wraps to 0 and the
//     vertical counter advances, else pixel_x++.
//   - Vertical counter: if pixel_y==V_TOTAL-1, pixel_y wraps to 0, else pixel_y++.
//     Both counters wrap on the same tick at frame end.
//   - Horizontal region FSM (HACT, HFP, HSYNC, HBP), one transition per region
//     boundary on tick: HACT->HFP at x=H_ACTIVE, HFP->HSYNC at H_ACTIVE+H_FP,
//     HSYNC->HBP at H_ACTIVE+H_FP+H_SYNC, HBP->HACT at wrap.
//   - Vertical region FSM (VACT, VFP, VSYNC, VBP) uses the same rules on line
//     boundaries.
//   - hsync=SYNC_POL exactly while the H FSM is in HSYNC (x=656..751 default);
//     vsync likewise in VSYNC (y=490..491).
//   - hsync, vsync and video_on are registered, glitch-free, and valid in the
//     same Clk as the pixel_x/pixel_y they describe (zero relative latency).
//   - enable=0: synchronous hold-at-origin. Next edge: divider=0, x=y=0,
//     FSMs=HACT/VACT, sync lines inactive, video_on=0.
//     First tick after enable returns to 1 occurs CLK_DIV clocks later; the
//     raster then starts at (0,0).
//   - Reset mid-line/mid-frame: immediate return to reset values. No partial
//     sync pulse is stretched.
//   - Counters are 10 bits; H_TOTAL and V_TOTAL must be <=1024. No arithmetic
//     exceeds 10 bits.
// TESTING
//   - Reset: hold reset=0 for 5 Clk -> x=0, y=0, hsync=vsync=1, video_on=0,
//     pixel_tick=0.
//   - Tick: enable=1, CLK_DIV=2 -> pixel_tick high on every 2nd Clk,
//     1600 Clk per line, line_end once per 800 ticks.
//   - Line: across one line -> hsync low for exactly 96 ticks starting at x=656;
//     video_on high for x=0..639 only.
//   - Frame: run 420000 ticks -> vsync low for y=490,491 (1600 ticks);
//     307200 ticks with video_on=1; one frame_end; x=y=0 after.
//   - Enable drop at x=300,y=200 -> next Clk x=y=0, syncs high.
//     Re-enable -> first tick after 2 Clk, raster resumes from (0,0).
//   - Async reset asserted mid-hsync (x=700) between edges -> outputs clear
//     before the next Clk edge; hsync returns high immediately.

Source files
------------

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: pixel-tick divider, horizontal/vertical counters and
// region FSMs, with registered sync/blanking outputs aligned to pixel_x/pixel_y.
module vga_timing_controller #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       enable,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_end,
  output logic       frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_ACT_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_LAST   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_LAST   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic       SYNC_ON     = (SYNC_POL != 0);

  typedef enum logic [1:0] {HACT, HFP, HSYNC, HBP} h_state_t;
  typedef enum logic [1:0] {VACT, VFP, VSYNC, VBP} v_state_t;

  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  h_state_t         r_hst;
  h_state_t         w_hst_nxt;
  v_state_t         r_vst;
  v_state_t         w_vst_nxt;
  logic             w_line_end;
  logic [9:0]       w_x_nxt;
  logic [9:0]       w_y_nxt;

  assign w_line_end = r_tick & (r_x == H_LAST);
  assign w_x_nxt    = (r_x == H_LAST) ? 10'd0 : r_x + 10'd1;
  assign w_y_nxt    = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;

  // Divider and counters; enable=0 parks everything at the origin.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
      r_x    <= 10'd0;
      r_y    <= 10'd0;
    end else if (!enable) begin
      r_div  <= '0;
      r_tick <= 1'b0;
      r_x    <= 10'd0;
      r_y    <= 10'd0;
    end else begin
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      r_tick <= (r_div == DIV_LAST);
      if (r_tick) begin
        r_x <= w_x_nxt;
        if (r_x == H_LAST) r_y <= w_y_nxt;
      end
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_hst <= HACT;
      r_vst <= VACT;
    end else begin
      r_hst <= w_hst_nxt;
      r_vst <= w_vst_nxt;
    end
  end

  // Each FSM moves on the tick that carries its counter across a region edge.
  always_comb begin
    w_hst_nxt = r_hst;
    if (!enable) begin
      w_hst_nxt = HACT;
    end else if (r_tick) begin
      case (r_hst)
        HACT:    if (r_x == H_ACT_LAST)  w_hst_nxt = HFP;
        HFP:     if (r_x == H_FP_LAST)   w_hst_nxt = HSYNC;
        HSYNC:   if (r_x == H_SYNC_LAST) w_hst_nxt = HBP;
        HBP:     if (r_x == H_LAST)      w_hst_nxt = HACT;
        default: w_hst_nxt = HACT;
      endcase
    end
  end

  always_comb begin
    w_vst_nxt = r_vst;
    if (!enable) begin
      w_vst_nxt = VACT;
    end else if (w_line_end) begin
      case (r_vst)
        VACT:    if (r_y == V_ACT_LAST)  w_vst_nxt = VFP;
        VFP:     if (r_y == V_FP_LAST)   w_vst_nxt = VSYNC;
        VSYNC:   if (r_y == V_SYNC_LAST) w_vst_nxt = VBP;
        VBP:     if (r_y == V_LAST)      w_vst_nxt = VACT;
        default: w_vst_nxt = VACT;
      endcase
    end
  end

  // Decoded from next state so the flags land in the same cycle as the counts.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_hsync    <= ~SYNC_ON;
      r_vsync    <= ~SYNC_ON;
      r_video_on <= 1'b0;
    end else begin
      r_hsync    <= (w_hst_nxt == HSYNC) ? SYNC_ON : ~SYNC_ON;
      r_vsync    <= (w_vst_nxt == VSYNC) ? SYNC_ON : ~SYNC_ON;
      r_video_on <= enable & (w_hst_nxt == HACT) & (w_vst_nxt == VACT);
    end
  end

  assign pixel_tick = r_tick;
  assign pixel_x    = r_x;
  assign pixel_y    = r_y;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign video_on   = r_video_on;
  assign line_end   = w_line_end;
  assign frame_end  = w_line_end & (r_y == V_LAST);

endmodule
